// File: rtl/dctq_mult_pkg.sv
// Shared constants and elaboration helpers for the DCTQ pipelined multiplier lanes.
package dctq_mult_pkg;

    localparam int unsigned DctqAW   = 8;
    localparam int unsigned DctqBW   = 8;
    localparam int unsigned DctqTagW = 6;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p * 2;
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int unsigned mult_lat(input int unsigned bw);
        return 2 + clog2(bw);
    endfunction

    // Number of operands left in the adder tree after k pairwise levels.
    function automatic int unsigned level_n(input int unsigned n0, input int unsigned k);
        int unsigned n;
        n = n0;
        for (int unsigned i = 0; i < k; i++) begin
            n = (n + 1) / 2;
        end
        return n;
    endfunction

endpackage

// File: rtl/mult_add_level.sv
// One registered adder-tree level: sums adjacent operand pairs, an odd last operand passes through.
module mult_add_level #(
    parameter int unsigned N  = 8,
    parameter int unsigned W  = 16,
    parameter int unsigned SW = 9
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ce_i,
    input  logic                      valid_i,
    input  logic [SW-1:0]             side_i,
    input  logic [N-1:0][W-1:0]       data_i,
    output logic                      valid_o,
    output logic [SW-1:0]             side_o,
    output logic [(N+1)/2-1:0][W-1:0] data_o
);

    localparam int unsigned NO = (N + 1) / 2;

    logic [NO-1:0][W-1:0] sum_d;
    logic [NO-1:0][W-1:0] sum_q;
    logic                 valid_q;
    logic [SW-1:0]        side_q;

    for (genvar i = 0; i < NO; i++) begin : g_pair
        if (2 * i + 1 < N) begin : g_add
            assign sum_d[i] = data_i[2*i] + data_i[2*i+1];
        end else begin : g_pass
            assign sum_d[i] = data_i[2*i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            valid_q <= 1'b0;
            side_q  <= '0;
        end else if (ce_i) begin
            sum_q   <= sum_d;
            valid_q <= valid_i;
            side_q  <= side_i;
        end
    end

    assign data_o  = sum_q;
    assign valid_o = valid_q;
    assign side_o  = side_q;

endmodule

// File: rtl/mult_pipe_param.sv
// Pipelined sign/magnitude multiplier with per-transaction signedness, tag sideband and
// whole-pipeline stall on valid/ready.
module mult_pipe_param
    import dctq_mult_pkg::*;
#(
    parameter int unsigned A_W   = DctqAW,
    parameter int unsigned B_W   = DctqBW,
    parameter int unsigned TAG_W = DctqTagW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [A_W-1:0]     a_i,
    input  logic [B_W-1:0]     b_i,
    input  logic               a_signed_i,
    input  logic               b_signed_i,
    input  logic [TAG_W-1:0]   in_tag_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [A_W+B_W-1:0] result_o,
    output logic               out_signed_o,
    output logic [TAG_W-1:0]   out_tag_o
);

    localparam int unsigned PW = A_W + B_W;
    localparam int unsigned NL = clog2(B_W);
    localparam int unsigned SW = TAG_W + 3;

    logic ce;

    logic             a_neg;
    logic             b_neg;
    logic [A_W-1:0]   mag_a_d, mag_a_q;
    logic [B_W-1:0]   mag_b_d, mag_b_q;
    logic             s1_valid_q;
    logic             s1_neg_q;
    logic             s1_zero_q;
    logic             s1_sgn_q;
    logic [TAG_W-1:0] s1_tag_q;
    logic [SW-1:0]    s1_side;

    logic [B_W-1:0][PW-1:0] pp;

    logic             fin_valid;
    logic [SW-1:0]    fin_side;
    logic [PW-1:0]    fin_mag;
    logic [PW-1:0]    result_d, result_q;
    logic             out_valid_q;
    logic             out_signed_q;
    logic [TAG_W-1:0] out_tag_q;

    assign ce         = out_ready_i | ~out_valid_q;
    assign in_ready_o = ce;

    always_comb begin
        a_neg   = a_signed_i & a_i[A_W-1];
        b_neg   = b_signed_i & b_i[B_W-1];
        // Negating the most negative value yields 2^(W-1), which still fits as unsigned.
        mag_a_d = a_neg ? (~a_i) + A_W'(1) : a_i;
        mag_b_d = b_neg ? (~b_i) + B_W'(1) : b_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_a_q    <= '0;
            mag_b_q    <= '0;
            s1_valid_q <= 1'b0;
            s1_neg_q   <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_sgn_q   <= 1'b0;
            s1_tag_q   <= '0;
        end else if (ce) begin
            mag_a_q    <= mag_a_d;
            mag_b_q    <= mag_b_d;
            s1_valid_q <= in_valid_i;
            s1_neg_q   <= a_neg ^ b_neg;
            s1_zero_q  <= (a_i == '0) | (b_i == '0);
            s1_sgn_q   <= a_signed_i | b_signed_i;
            s1_tag_q   <= in_tag_i;
        end
    end

    assign s1_side = {s1_neg_q, s1_zero_q, s1_sgn_q, s1_tag_q};

    always_comb begin
        for (int i = 0; i < B_W; i++) begin
            pp[i] = mag_b_q[i] ? (PW'(mag_a_q) << i) : '0;
        end
    end

    // Full product width at every level, so no carry can be dropped.
    for (genvar k = 1; k <= NL; k++) begin : g_lvl
        localparam int unsigned NI = level_n(B_W, k - 1);
        localparam int unsigned NO = level_n(B_W, k);

        logic [NI-1:0][PW-1:0] din;
        logic                  vin;
        logic [SW-1:0]         sin;
        logic [NO-1:0][PW-1:0] dout;
        logic                  vout;
        logic [SW-1:0]         sout;

        if (k == 1) begin : g_first
            assign din = pp;
            assign vin = s1_valid_q;
            assign sin = s1_side;
        end else begin : g_next
            assign din = g_lvl[k-1].dout;
            assign vin = g_lvl[k-1].vout;
            assign sin = g_lvl[k-1].sout;
        end

        mult_add_level #(
            .N  (NI),
            .W  (PW),
            .SW (SW)
        ) u_level (
            .clk     (clk),
            .rst_n   (rst_n),
            .ce_i    (ce),
            .valid_i (vin),
            .side_i  (sin),
            .data_i  (din),
            .valid_o (vout),
            .side_o  (sout),
            .data_o  (dout)
        );
    end

    assign fin_valid = g_lvl[NL].vout;
    assign fin_side  = g_lvl[NL].sout;
    assign fin_mag   = g_lvl[NL].dout[0];

    always_comb begin
        if (fin_side[SW-2]) begin
            result_d = '0;
        end else if (fin_side[SW-1]) begin
            result_d = (~fin_mag) + PW'(1);
        end else begin
            result_d = fin_mag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            result_q     <= '0;
            out_signed_q <= 1'b0;
            out_tag_q    <= '0;
        end else if (ce) begin
            out_valid_q  <= fin_valid;
            result_q     <= result_d;
            out_signed_q <= fin_side[SW-3];
            out_tag_q    <= fin_side[TAG_W-1:0];
        end
    end

    assign out_valid_o  = out_valid_q;
    assign result_o     = result_q;
    assign out_signed_o = out_signed_q;
    assign out_tag_o    = out_tag_q;

endmodule

// File: tb/tb_mult_pipe_param.sv
// Directed bench for mult_pipe_param: 8x8 lane plus an A_W=12 sweep over several B_W values.
module tb_mult_pipe_param;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // 8x8 lane
    logic        in_valid, in_ready, a_s, b_s, out_valid, out_ready, out_signed;
    logic [7:0]  a, b;
    logic [5:0]  in_tag, out_tag;
    logic [15:0] result;

    mult_pipe_param #(.A_W(8), .B_W(8), .TAG_W(6)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .a_i          (a),
        .b_i          (b),
        .a_signed_i   (a_s),
        .b_signed_i   (b_s),
        .in_tag_i     (in_tag),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .result_o     (result),
        .out_signed_o (out_signed),
        .out_tag_o    (out_tag)
    );

    function automatic int unsigned sweep_bw(input int unsigned i);
        case (i)
            0:       return 2;
            1:       return 5;
            2:       return 11;
            default: return 16;
        endcase
    endfunction

    function automatic int sweep_lat(input int unsigned i);
        case (i)
            0:       return 3;
            1:       return 5;
            default: return 6;
        endcase
    endfunction

    // A_W = 12 sweep lanes, all driven together
    logic        sw_valid, sw_as, sw_bs;
    logic [11:0] sw_a;
    logic [5:0]  sw_tag;
    logic [15:0] sw_b   [4];
    logic        sw_ir  [4];
    logic        sw_ov  [4];
    logic [27:0] sw_res [4];
    logic        sw_os  [4];
    logic [5:0]  sw_ot  [4];

    for (genvar g = 0; g < 4; g++) begin : g_sw
        localparam int unsigned Bw = sweep_bw(g);
        logic [12+Bw-1:0] res;
        mult_pipe_param #(.A_W(12), .B_W(Bw), .TAG_W(6)) u_sw (
            .clk          (clk),
            .rst_n        (rst_n),
            .in_valid_i   (sw_valid),
            .in_ready_o   (sw_ir[g]),
            .a_i          (sw_a),
            .b_i          (sw_b[g][Bw-1:0]),
            .a_signed_i   (sw_as),
            .b_signed_i   (sw_bs),
            .in_tag_i     (sw_tag),
            .out_valid_o  (sw_ov[g]),
            .out_ready_i  (1'b1),
            .result_o     (res),
            .out_signed_o (sw_os[g]),
            .out_tag_o    (sw_ot[g])
        );
        assign sw_res[g] = 28'(res);
    end

    // Reference: true integer product, truncated to aw+bw bits.
    function automatic logic [31:0] ref_mul(input logic [15:0] av_in, input logic [15:0] bv_in,
                                            input logic as, input logic bs,
                                            input int aw, input int bw);
        longint av, bv, p;
        av = longint'(av_in) & ((longint'(1) << aw) - 1);
        bv = longint'(bv_in) & ((longint'(1) << bw) - 1);
        if (as && av_in[aw-1]) av = av - (longint'(1) << aw);
        if (bs && bv_in[bw-1]) bv = bv - (longint'(1) << bw);
        p = av * bv;
        return 32'(p & ((longint'(1) << (aw + bw)) - 1));
    endfunction

    // Single transaction on the 8x8 lane; lat counts edges with the accepting edge as 1.
    task automatic drive_single(input logic [7:0] ta, input logic [7:0] tb, input logic tas,
                                input logic tbs, input logic [5:0] ttag, output int lat,
                                output logic [15:0] res, output logic sgn,
                                output logic [5:0] otag);
        @(posedge clk); #1;
        a = ta; b = tb; a_s = tas; b_s = tbs; in_tag = ttag; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result; sgn = out_signed; otag = out_tag;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++;
        if (result !== 16'h0) begin n_fail++; $display("FAIL reset_result got %h want 0000", result); end
        n_checks++;
        if (out_signed !== 1'b0) begin n_fail++; $display("FAIL reset_out_signed got %b want 0", out_signed); end
        n_checks++;
        if (out_tag !== 6'h0) begin n_fail++; $display("FAIL reset_out_tag got %h want 00", out_tag); end
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_mixed_sign();
        int lat; logic [15:0] res; logic sgn; logic [5:0] ot;
        drive_single(8'd255, 8'h80, 1'b0, 1'b1, 6'd5, lat, res, sgn, ot);
        n_checks++;
        if (lat !== 5) begin n_fail++; $display("FAIL mixed_latency got %0d want 5", lat); end
        n_checks++;
        if (res !== 16'h8080) begin n_fail++; $display("FAIL mixed_result got %h want 8080", res); end
        n_checks++;
        if (sgn !== 1'b1) begin n_fail++; $display("FAIL mixed_signed got %b want 1", sgn); end
        n_checks++;
        if (ot !== 6'd5) begin n_fail++; $display("FAIL mixed_tag got %0d want 5", ot); end
        drive_single(8'h80, 8'h80, 1'b1, 1'b1, 6'd9, lat, res, sgn, ot);
        n_checks++;
        if (res !== 16'h4000) begin n_fail++; $display("FAIL minmin_result got %h want 4000", res); end
        n_checks++;
        if (sgn !== 1'b1) begin n_fail++; $display("FAIL minmin_signed got %b want 1", sgn); end
    endtask

    task automatic test_unsigned();
        int lat; logic [15:0] res; logic sgn; logic [5:0] ot;
        drive_single(8'd255, 8'd255, 1'b0, 1'b0, 6'd33, lat, res, sgn, ot);
        n_checks++;
        if (res !== 16'hFE01) begin n_fail++; $display("FAIL unsigned_result got %h want fe01", res); end
        n_checks++;
        if (sgn !== 1'b0) begin n_fail++; $display("FAIL unsigned_signed got %b want 0", sgn); end
        n_checks++;
        if (ot !== 6'd33) begin n_fail++; $display("FAIL unsigned_tag got %0d want 33", ot); end
    endtask

    task automatic test_zero();
        int lat; logic [15:0] res; logic sgn; logic [5:0] ot;
        drive_single(8'd0, 8'h81, 1'b0, 1'b1, 6'd2, lat, res, sgn, ot);
        n_checks++;
        if (res !== 16'h0000) begin n_fail++; $display("FAIL zero_result got %h want 0000", res); end
        n_checks++;
        if (sgn !== 1'b1) begin n_fail++; $display("FAIL zero_signed got %b want 1", sgn); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  va [20];
        logic [7:0]  vb [20];
        logic        vas [20];
        logic        vbs [20];
        logic [15:0] ve [20];
        logic [31:0] e32;
        int sent, rcv, cyc, extra;
        for (int i = 0; i < 20; i++) begin
            va[i] = 8'($urandom); vb[i] = 8'($urandom);
            vas[i] = 1'($urandom_range(0, 1)); vbs[i] = 1'($urandom_range(0, 1));
        end
        va[3] = 8'h80; vb[3] = 8'h7F; vas[3] = 1'b1; vbs[3] = 1'b1;
        va[7] = 8'h00; vb[7] = 8'hFF; vas[7] = 1'b1; vbs[7] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            e32 = ref_mul({8'h0, va[i]}, {8'h0, vb[i]}, vas[i], vbs[i], 8, 8);
            ve[i] = e32[15:0];
        end
        sent = 0; rcv = 0; cyc = 0;
        while (rcv < 20 && cyc < 200) begin
            @(posedge clk); #1;
            out_ready = !(cyc >= 8 && cyc < 11);
            if (sent < 20) begin
                in_valid = 1'b1; a = va[sent]; b = vb[sent];
                a_s = vas[sent]; b_s = vbs[sent]; in_tag = 6'(sent);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (!out_ready) begin
                n_checks++;
                if (in_ready !== 1'b0) begin
                    n_fail++; $display("FAIL stall_in_ready cyc %0d got %b want 0", cyc, in_ready);
                end
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                n_checks++;
                if (out_tag !== 6'(rcv)) begin
                    n_fail++; $display("FAIL b2b_tag got %0d want %0d", out_tag, rcv);
                end
                n_checks++;
                if (result !== ve[rcv]) begin
                    n_fail++; $display("FAIL b2b_result #%0d got %h want %h", rcv, result, ve[rcv]);
                end
                rcv++;
            end
            cyc++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        n_checks++;
        if (rcv !== 20) begin n_fail++; $display("FAIL b2b_count got %0d want 20", rcv); end
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) extra++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (extra !== 0) begin n_fail++; $display("FAIL b2b_duplicates got %0d want 0", extra); end
    endtask

    task automatic test_reset_midflight();
        int seen;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = 8'(8'h31 + i); b = 8'h22; a_s = 1'b0; b_s = 1'b0;
            in_tag = 6'(40 + i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
        n_checks++;
        if (result !== 16'h0) begin n_fail++; $display("FAIL midrst_result got %h want 0000", result); end
        n_checks++;
        if (out_tag !== 6'h0) begin n_fail++; $display("FAIL midrst_tag got %0d want 0", out_tag); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL midrst_ghost_outputs got %0d want 0", seen); end
    endtask

    task automatic test_param_sweep();
        logic [11:0] ta;
        logic        tas, tbs;
        int          lat [4];
        logic [27:0] res [4];
        logic        os  [4];
        logic [5:0]  ot  [4];
        bit          got [4];
        logic [31:0] e32;
        int unsigned bw;
        for (int j = 0; j < 6; j++) begin
            @(posedge clk); #1;
            case (j)
                0: begin ta = 12'hFFF; tas = 1'b0; tbs = 1'b0; end
                1: begin ta = 12'h800; tas = 1'b1; tbs = 1'b1; end
                2: begin ta = 12'h7FF; tas = 1'b1; tbs = 1'b1; end
                3: begin ta = 12'h000; tas = 1'b1; tbs = 1'b1; end
                default: begin
                    ta = 12'($urandom); tas = 1'($urandom_range(0, 1));
                    tbs = 1'($urandom_range(0, 1));
                end
            endcase
            for (int i = 0; i < 4; i++) begin
                bw = sweep_bw(i);
                if (j == 0) sw_b[i] = 16'((32'd1 << bw) - 1);
                else if (j < 4) sw_b[i] = 16'(32'd1 << (bw - 1));
                else sw_b[i] = 16'($urandom) & 16'((32'd1 << bw) - 1);
                got[i] = 1'b0; lat[i] = 0; res[i] = '0; os[i] = 1'b0; ot[i] = '0;
            end
            sw_a = ta; sw_as = tas; sw_bs = tbs; sw_tag = 6'(j + 1); sw_valid = 1'b1;
            @(posedge clk); #1;
            sw_valid = 1'b0;
            for (int n = 1; n <= 12; n++) begin
                for (int i = 0; i < 4; i++) begin
                    if (sw_ov[i] && !got[i]) begin
                        got[i] = 1'b1; lat[i] = n; res[i] = sw_res[i];
                        os[i] = sw_os[i]; ot[i] = sw_ot[i];
                    end
                end
                @(posedge clk); #1;
            end
            for (int i = 0; i < 4; i++) begin
                bw = sweep_bw(i);
                e32 = ref_mul({4'h0, ta}, sw_b[i], tas, tbs, 12, int'(bw));
                n_checks++;
                if (lat[i] !== sweep_lat(i)) begin
                    n_fail++;
                    $display("FAIL sweep_latency bw=%0d got %0d want %0d", bw, lat[i], sweep_lat(i));
                end
                n_checks++;
                if (res[i] !== 28'(e32)) begin
                    n_fail++;
                    $display("FAIL sweep_result bw=%0d vec=%0d got %h want %h", bw, j, res[i], 28'(e32));
                end
                n_checks++;
                if (os[i] !== (tas | tbs) || ot[i] !== 6'(j + 1)) begin
                    n_fail++;
                    $display("FAIL sweep_sideband bw=%0d got %b/%0d want %b/%0d", bw, os[i], ot[i],
                             tas | tbs, j + 1);
                end
            end
        end
    endtask

    initial begin
        in_valid = 1'b0; a = '0; b = '0; a_s = 1'b0; b_s = 1'b0; in_tag = '0; out_ready = 1'b1;
        sw_valid = 1'b0; sw_a = '0; sw_as = 1'b0; sw_bs = 1'b0; sw_tag = '0;
        for (int i = 0; i < 4; i++) sw_b[i] = '0;
        test_reset();
        test_mixed_sign();
        test_unsigned();
        test_zero();
        test_back_to_back();
        test_reset_midflight();
        test_param_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
